// File: rtl/arb_requester.sv
// Requester-side agent for the 3-master shared-resource arbiter.
// Turns a "transfer N beats" command into req / beats / done, re-requesting on grant loss.
module arb_requester #(
    parameter logic [1:0] MODULE_ID   = 2'b01,
    parameter int         LEN_W       = 8,
    parameter int         REQ_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [1:0]       accmodule,
    output logic             req,
    output logic             done,
    output logic             busy,
    output logic             beat_valid,
    output logic [LEN_W-1:0] remaining,
    output logic [7:0]       nb_preempt
);

    localparam int CNT_W = $clog2(REQ_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REQ_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_XFER,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       pre_q, pre_d;
    logic             granted;
    logic             beat;

    assign granted = (accmodule == MODULE_ID);

    // A stale grant seen in REQ, IDLE or DONE never moves data.
    assign beat = ((state_q == S_WAIT) || (state_q == S_XFER))
                  && granted && (rem_q != '0);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && (len != '0)) begin
                    rem_d   = len;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (beat) begin
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_q == LEN_W'(1)) ? S_DONE : S_XFER;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_REQ;
                end
            end
            S_XFER: begin
                if (beat) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end else begin
                    pre_d   = (pre_q != 8'hFF) ? pre_q + 8'd1 : pre_q;
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
        end
    end

    assign req        = (state_q == S_REQ);
    assign done       = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign beat_valid = beat;
    assign remaining  = rem_q;
    assign nb_preempt = pre_q;

endmodule

// File: tb/tb_arb_requester.sv
// Directed and random-sweep bench for arb_requester (MODULE_ID=2'b10).
// A transfer-level model is compared every cycle; literal checks pin the model.
module tb_arb_requester;

    localparam logic [1:0] ID = 2'b10;
    localparam int         TO = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic [1:0] accmodule = 2'b00;
    logic       req, done, busy, beat_valid;
    logic [7:0] remaining, nb_preempt;

    int errors = 0;
    int checks = 0;

    arb_requester #(
        .MODULE_ID  (ID),
        .LEN_W      (8),
        .REQ_TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .accmodule (accmodule),
        .req       (req),
        .done      (done),
        .busy      (busy),
        .beat_valid(beat_valid),
        .remaining (remaining),
        .nb_preempt(nb_preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
        end
    endtask

    // Transfer-level model: beats left, pending req/done pulse,
    // whether a beat has moved since the last req, cycles waited.
    int m_left  = 0;
    int m_len   = 0;
    int m_pre   = 0;
    int m_since = 0;
    bit m_req   = 0;
    bit m_done  = 0;
    bit m_got   = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_left <= 0; m_req <= 0; m_done <= 0;
            m_got <= 0; m_since <= 0; m_pre <= 0;
        end else if (m_done) begin
            m_done <= 0;
        end else if (m_left == 0) begin
            if (start && len != 0) begin
                m_left <= int'(len);
                m_len  <= int'(len);
                m_req  <= 1;
            end
        end else if (m_req) begin
            m_req <= 0; m_since <= 0; m_got <= 0;
        end else if (accmodule == ID) begin
            m_left <= m_left - 1;
            m_got  <= 1;
            if (m_left == 1) m_done <= 1;
        end else if (m_got) begin
            m_pre <= (m_pre == 255) ? 255 : m_pre + 1;
            m_req <= 1;
        end else if (m_since == TO - 1) begin
            m_req <= 1;
        end else begin
            m_since <= m_since + 1;
        end
    end

    bit en = 0;
    bit prev_req = 0;
    bit prev_done = 0;
    int beat_cnt = 0;

    always @(negedge clk) begin
        if (en) begin
            chk("req", req, m_req);
            chk("done", done, m_done);
            chk("busy", busy, (m_left != 0) || m_done);
            chk("beat", beat_valid,
                (m_left != 0) && !m_req && (accmodule == ID));
            chk("remaining", remaining, m_left);
            chk("nb_preempt", nb_preempt, m_pre);
            chk("req_twice", req && prev_req, 0);
            chk("done_twice", done && prev_done, 0);
            chk("req_and_done", req && done, 0);
            if (done) begin
                chk("beats_per_done", beat_cnt, m_len);
                beat_cnt = 0;
            end else if (beat_valid) begin
                beat_cnt++;
            end
            if (reset) beat_cnt = 0;
            prev_req  = req;
            prev_done = done;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic r, input logic b, input logic d,
                        input logic bs, input int rem, input int np);
        @(negedge clk);
        chk("lit_req", req, r);
        chk("lit_beat", beat_valid, b);
        chk("lit_done", done, d);
        chk("lit_busy", busy, bs);
        chk("lit_rem", remaining, rem);
        chk("lit_npre", nb_preempt, np);
    endtask

    initial begin
        tick; tick;
        reset = 0; en = 1;
        look(0, 0, 0, 0, 0, 0);

        // basic len=3
        start = 1; len = 3; tick;
        start = 0; look(1, 0, 0, 1, 3, 0); tick;
        accmodule = ID;
        look(0, 1, 0, 1, 3, 0); tick;
        look(0, 1, 0, 1, 2, 0); tick;
        look(0, 1, 0, 1, 1, 0); tick;
        look(0, 0, 1, 1, 0, 0); tick;
        look(0, 0, 0, 0, 0, 0);

        // preemption len=5
        accmodule = 2'b00;
        start = 1; len = 5; tick;
        start = 0; look(1, 0, 0, 1, 5, 0); tick;
        accmodule = ID;
        look(0, 1, 0, 1, 5, 0); tick;
        look(0, 1, 0, 1, 4, 0); tick;
        accmodule = 2'b01;
        look(0, 0, 0, 1, 3, 0); tick;
        look(1, 0, 0, 1, 3, 1); tick;
        accmodule = 2'b00;
        look(0, 0, 0, 1, 3, 1); tick;
        accmodule = ID;
        look(0, 1, 0, 1, 3, 1); tick;
        look(0, 1, 0, 1, 2, 1); tick;
        look(0, 1, 0, 1, 1, 1); tick;
        look(0, 0, 1, 1, 0, 1); tick;
        look(0, 0, 0, 0, 0, 1);

        // reset mid-transfer at remaining=4
        start = 1; len = 6; tick;
        start = 0; look(1, 0, 0, 1, 6, 1); tick;
        look(0, 1, 0, 1, 6, 1); tick;
        look(0, 1, 0, 1, 5, 1); tick;
        reset = 1;
        look(0, 1, 0, 1, 4, 1); tick;
        reset = 0;
        look(0, 0, 0, 0, 0, 0);
        start = 1; len = 1; tick;
        start = 0; look(1, 0, 0, 1, 1, 0); tick;
        look(0, 1, 0, 1, 1, 0); tick;
        look(0, 0, 1, 1, 0, 0); tick;
        look(0, 0, 0, 0, 0, 0);

        // timeout: req every TO+1 cycles, never done
        accmodule = 2'b00;
        start = 1; len = 2; tick;
        start = 0;
        for (int k = 1; k <= 28; k++) begin
            look((k % (TO + 1)) == 1, 0, 0, 1, 2, 0);
            tick;
        end
        reset = 1; tick;
        reset = 0;

        // ignored commands
        accmodule = ID;
        start = 1; len = 0; tick;
        start = 0; look(0, 0, 0, 0, 0, 0);
        start = 1; len = 4; tick;
        start = 0; look(1, 0, 0, 1, 4, 0); tick;
        look(0, 1, 0, 1, 4, 0); tick;
        start = 1; len = 200;
        look(0, 1, 0, 1, 3, 0); tick;
        start = 0; look(0, 1, 0, 1, 2, 0); tick;
        look(0, 1, 0, 1, 1, 0); tick;
        look(0, 0, 1, 1, 0, 0); tick;
        look(0, 0, 0, 0, 0, 0);

        // random protocol sweep
        for (int n = 0; n < 10000; n++) begin
            int r;
            reset = ($urandom_range(0, 499) == 0);
            start = ($urandom_range(0, 3) == 0);
            len   = 8'($urandom_range(0, 6));
            r     = int'($urandom_range(0, 5));
            accmodule = (r >= 3) ? ID : 2'(r);
            tick;
        end
        reset = 0; start = 0; accmodule = 2'b00;
        repeat (20) tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
